// File: rtl/seg7_pkg.sv
// Shared 7-segment pattern constants (active-low, bit order g f e d c b a).
// Used by both the encoder side and the scan decoder.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of an active-low segment pattern back to BCD.
// Anything that is neither a digit nor blank reports both flags low.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n_i,
  output logic [3:0] bcd_o,
  output logic       is_digit_o,
  output logic       is_blank_o
);

  always_comb begin
    bcd_o      = 4'd0;
    is_digit_o = 1'b1;
    is_blank_o = 1'b0;
    case (seg_n_i)
      SEG_0:     bcd_o = 4'd0;
      SEG_1:     bcd_o = 4'd1;
      SEG_2:     bcd_o = 4'd2;
      SEG_3:     bcd_o = 4'd3;
      SEG_4:     bcd_o = 4'd4;
      SEG_5:     bcd_o = 4'd5;
      SEG_6:     bcd_o = 4'd6;
      SEG_7:     bcd_o = 4'd7;
      SEG_8:     bcd_o = 4'd8;
      SEG_9:     bcd_o = 4'd9;
      SEG_BLANK: begin
        is_digit_o = 1'b0;
        is_blank_o = 1'b1;
      end
      default:   is_digit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive side of the multiplexed 7-segment scan: qualifies a stable
// {segments, one-hot digit} sample for STABLE_CYCLES edges, then decodes it into its slot.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NDIGITS       = 6,
  parameter int STABLE_CYCLES = 4,
  localparam int IW           = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           seg_n,
  input  logic [NDIGITS-1:0]   dig_sel,
  input  logic                 err_clr,
  output logic [4*NDIGITS-1:0] bcd_out,
  output logic [NDIGITS-1:0]   digit_valid,
  output logic [NDIGITS-1:0]   invalid_seen,
  output logic                 update,
  output logic [IW-1:0]        update_idx
);

  localparam int             CW      = $clog2(STABLE_CYCLES + 1);
  localparam int             SW      = 7 + NDIGITS;
  localparam logic [CW-1:0]  RUN_MAX = CW'(STABLE_CYCLES);

  logic [SW-1:0]        prev_q;
  logic [CW-1:0]        run_q, run_d;
  logic                 cap_q, cap_d;
  logic [4*NDIGITS-1:0] bcd_q, bcd_d;
  logic [NDIGITS-1:0]   vld_q, vld_d;
  logic [NDIGITS-1:0]   inv_q, inv_d;
  logic                 upd_q;
  logic [IW-1:0]        idx_q, idx_d;

  logic [SW-1:0]        cur_sample;
  logic                 one_hot;
  logic                 same;
  logic                 capture;
  logic [IW-1:0]        sel_idx;
  logic [3:0]           dec_bcd;
  logic                 dec_digit;
  logic                 dec_blank;

  seg7_pattern_decode u_decode (
    .seg_n_i    (seg_n),
    .bcd_o      (dec_bcd),
    .is_digit_o (dec_digit),
    .is_blank_o (dec_blank)
  );

  assign cur_sample = {seg_n, dig_sel};
  assign one_hot    = (dig_sel != '0) && ((dig_sel & (dig_sel - NDIGITS'(1))) == '0);
  assign same       = (cur_sample == prev_q);

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (dig_sel[i]) sel_idx = IW'(i);
    end
  end

  // Run length counts edges including the first one of a new sample.
  always_comb begin
    run_d = '0;
    if (one_hot) begin
      if (!same)                run_d = CW'(1);
      else if (run_q < RUN_MAX) run_d = run_q + CW'(1);
      else                      run_d = RUN_MAX;
    end
  end

  assign capture = one_hot && (run_d == RUN_MAX) && !cap_q;

  always_comb begin
    if (capture)                cap_d = 1'b1;
    else if (!one_hot || !same) cap_d = 1'b0;
    else                        cap_d = cap_q;
  end

  // Only the selected slot is touched; a set on the same edge beats err_clr.
  always_comb begin
    bcd_d = bcd_q;
    vld_d = vld_q;
    inv_d = err_clr ? '0 : inv_q;
    idx_d = idx_q;
    if (capture) begin
      idx_d = sel_idx;
      for (int i = 0; i < NDIGITS; i++) begin
        if (dig_sel[i]) begin
          if (dec_digit) begin
            bcd_d[4*i +: 4] = dec_bcd;
            vld_d[i]        = 1'b1;
          end else begin
            vld_d[i] = 1'b0;
            if (!dec_blank) inv_d[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
      run_q  <= '0;
      cap_q  <= 1'b0;
      bcd_q  <= '0;
      vld_q  <= '0;
      inv_q  <= '0;
      upd_q  <= 1'b0;
      idx_q  <= '0;
    end else begin
      prev_q <= cur_sample;
      run_q  <= run_d;
      cap_q  <= cap_d;
      bcd_q  <= bcd_d;
      vld_q  <= vld_d;
      inv_q  <= inv_d;
      upd_q  <= capture;
      idx_q  <= idx_d;
    end
  end

  assign bcd_out      = bcd_q;
  assign digit_valid  = vld_q;
  assign invalid_seen = inv_q;
  assign update       = upd_q;
  assign update_idx   = idx_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed, table-driven bench for seg7_scan_decoder (NDIGITS=6, STABLE_CYCLES=4),
// plus a hand-written sequence for reset in the middle of a run.
module tb_seg7_scan_decoder;

  logic        clk;
  logic        reset;
  logic [6:0]  seg_n;
  logic [5:0]  dig_sel;
  logic        err_clr;
  logic [23:0] bcd_out;
  logic [5:0]  digit_valid;
  logic [5:0]  invalid_seen;
  logic        update;
  logic [2:0]  update_idx;

  int n_checks = 0;
  int n_errors = 0;

  seg7_scan_decoder #(.NDIGITS(6), .STABLE_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .seg_n        (seg_n),
    .dig_sel      (dig_sel),
    .err_clr      (err_clr),
    .bcd_out      (bcd_out),
    .digit_valid  (digit_valid),
    .invalid_seen (invalid_seen),
    .update       (update),
    .update_idx   (update_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One record = inputs held for n edges; update expected only on edge upd_at (0 = never).
  typedef struct {
    logic [6:0]  seg;
    logic [5:0]  dig;
    logic        clr;
    int          n;
    int          upd_at;
    int          idx;
    logic [23:0] bcd;
    logic [5:0]  vld;
    logic [5:0]  inv;
  } vec_t;

  localparam int NV = 12;
  vec_t tbl [NV];

  initial begin
    tbl[0]  = '{7'h12, 6'b000100, 1'b0, 14, 4, 2, 24'h000500, 6'b000100, 6'b000000}; // 5 -> slot 2, held
    tbl[1]  = '{7'h30, 6'b000100, 1'b0,  3, 0, 0, 24'h000500, 6'b000100, 6'b000000}; // 3 edges only
    tbl[2]  = '{7'h7F, 6'b000000, 1'b0,  2, 0, 0, 24'h000500, 6'b000100, 6'b000000}; // no digit selected
    tbl[3]  = '{7'h55, 6'b000001, 1'b0,  4, 4, 0, 24'h000500, 6'b000100, 6'b000001}; // illegal on slot 0
    tbl[4]  = '{7'h55, 6'b000001, 1'b1,  1, 0, 0, 24'h000500, 6'b000100, 6'b000000}; // err_clr
    tbl[5]  = '{7'h79, 6'b000011, 1'b0, 10, 0, 0, 24'h000500, 6'b000100, 6'b000000}; // two-hot
    tbl[6]  = '{7'h79, 6'b000001, 1'b0,  4, 4, 0, 24'h000501, 6'b000101, 6'b000000}; // 1 -> slot 0
    tbl[7]  = '{7'h00, 6'b001000, 1'b0,  4, 4, 3, 24'h008501, 6'b001101, 6'b000000}; // 8 -> slot 3
    tbl[8]  = '{7'h7F, 6'b001000, 1'b0,  4, 4, 3, 24'h008501, 6'b000101, 6'b000000}; // blank slot 3
    tbl[9]  = '{7'h55, 6'b010000, 1'b0,  4, 4, 4, 24'h008501, 6'b000101, 6'b010000}; // illegal slot 4
    tbl[10] = '{7'h55, 6'b100000, 1'b0,  3, 0, 0, 24'h008501, 6'b000101, 6'b010000}; // slot 5 run
    tbl[11] = '{7'h55, 6'b100000, 1'b1,  1, 1, 5, 24'h008501, 6'b000101, 6'b100000}; // set beats clear
  end

  initial begin
    reset   = 1'b1;
    seg_n   = 7'h7F;
    dig_sel = 6'b0;
    err_clr = 1'b0;
    #12;
    chk("reset_bcd", 32'(bcd_out), 32'h0);
    chk("reset_valid", 32'(digit_valid), 32'h0);
    chk("reset_invalid", 32'(invalid_seen), 32'h0);
    chk("reset_update", 32'(update), 32'h0);
    chk("reset_idx", 32'(update_idx), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < NV; v++) begin
      for (int e = 1; e <= tbl[v].n; e++) begin
        @(negedge clk);
        seg_n   = tbl[v].seg;
        dig_sel = tbl[v].dig;
        err_clr = tbl[v].clr;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_e%0d_update", v, e), 32'(update), 32'(e == tbl[v].upd_at));
        if (e == tbl[v].upd_at)
          chk($sformatf("v%0d_idx", v), 32'(update_idx), 32'(tbl[v].idx));
      end
      chk($sformatf("v%0d_bcd", v), 32'(bcd_out), 32'(tbl[v].bcd));
      chk($sformatf("v%0d_valid", v), 32'(digit_valid), 32'(tbl[v].vld));
      chk($sformatf("v%0d_invalid", v), 32'(invalid_seen), 32'(tbl[v].inv));
    end

    // Reset lands two edges into a run of 7 on slot 1; run must restart afterwards.
    @(negedge clk);
    seg_n   = 7'h78;
    dig_sel = 6'b000010;
    err_clr = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_bcd", 32'(bcd_out), 32'h0);
    chk("midrst_valid", 32'(digit_valid), 32'h0);
    chk("midrst_invalid", 32'(invalid_seen), 32'h0);
    chk("midrst_update", 32'(update), 32'h0);
    chk("midrst_idx", 32'(update_idx), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst_e%0d_update", e), 32'(update), 32'(e == 4));
    end
    chk("post_rst_idx", 32'(update_idx), 32'h1);
    chk("post_rst_bcd", 32'(bcd_out), 32'h000070);
    chk("post_rst_valid", 32'(digit_valid), 32'h02);
    chk("post_rst_invalid", 32'(invalid_seen), 32'h0);
    @(posedge clk);
    #1;
    chk("post_rst_update_drop", 32'(update), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
Receive side of the multiplexed 7-segment display interface. Samples the active-low segment bus and the one-hot digit-select lines, qualifies each digit by requiring a stable pattern, and decodes it back to BCD per digit slot. Used as a loopback checker and display monitor behind the BCD-to-segment encoders and scan driver.

Parameters:
NDIGITS, 6, number of digit slots / width of dig_sel
STABLE_CYCLES, 4, consecutive identical samples required before capture (legal range 1..255)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
seg_n  input  7  segment bus, active-low, bit order 6543210 = g f e d c b a
dig_sel  input  NDIGITS  digit select, active-high, expected one-hot
err_clr  input  1  synchronous clear of invalid_seen
bcd_out  output  4*NDIGITS  captured BCD, slot i at bits [4i+3:4i]
digit_valid  output  NDIGITS  slot i holds a legal decoded digit
invalid_seen  output  NDIGITS  sticky: slot i captured an illegal pattern
update  output  1  one-cycle pulse: a slot was loaded this edge
update_idx  output  $clog2(NDIGITS) (min 1)  index of slot loaded, valid with update

Behaviour:
- Reset (async, active-high): bcd_out=0, digit_valid=0, invalid_seen=0, update=0, update_idx=0, internal prev sample=0, run counter=0, captured flag=0.
- Legal patterns (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Blank=1111111. Anything else illegal.
- Each edge compares {seg_n, dig_sel} with the previous sample; prev register always loads the current sample.
- dig_sel not one-hot (zero or multiple bits): run counter<=0, captured<=0, no capture.
- One-hot and differs from previous: run counter<=1, captured<=0.
- One-hot and equal to previous: counter increments, saturating at STABLE_CYCLES.
- Capture occurs at the edge where the run length (edges including the first) reaches STABLE_CYCLES and captured=0; captured<=1 so a held pattern captures exactly once per run. STABLE_CYCLES=1 captures on the first edge of a new one-hot sample.
- At capture for slot i (index of the dig_sel bit): legal digit -> bcd slot i<=value, digit_valid[i]<=1; blank -> bcd slot i unchanged, digit_valid[i]<=0; illegal -> bcd slot i unchanged, digit_valid[i]<=0, invalid_seen[i]<=1. update<=1, update_idx<=i for all three cases.
- update is high for exactly one cycle following the capture edge; otherwise 0.
- Latency: inputs change before edge 1 and stay constant -> outputs and update visible after edge STABLE_CYCLES.
- err_clr clears all invalid_seen bits; if an illegal capture hits the same edge, that slot's bit is set (set wins), others cleared.
- Other slots are never disturbed by a capture.
- Reset asserted mid-run: everything returns to reset values immediately; a run restarts from count 0 after release.
- Counter width $clog2(STABLE_CYCLES+1); no wrap (saturating).

Decomposition:
- Package seg7_pkg: 7-bit pattern constants SEG_0..SEG_9, SEG_BLANK; shared with the encoder side.
- Sub-module seg7_pattern_decode (combinational): seg_n -> bcd[3:0], is_digit, is_blank. Instantiated once in the capture path.
- One-hot check and index encode are local logic.

Test Plan:
- Reset then seg_n=0010010, dig_sel=000100 held 4 edges -> after edge 4 update=1, update_idx=2, bcd_out[11:8]=5, digit_valid=000100; no further update while held 10 more edges.
- Same stimulus held only 3 edges then changed -> no update, outputs unchanged.
- seg_n=1010101 on dig_sel=000001 for 4 edges -> invalid_seen[0]=1, digit_valid[0]=0, bcd slot 0 unchanged, update pulses; err_clr next cycle -> invalid_seen=0.
- dig_sel=000011 with seg_n=1111001 for 10 edges -> no update, no state change; then dig_sel=000001 for 4 edges -> slot 0 = 1, valid.
- Load digit 8 into slot 3, then send blank (1111111) to slot 3 for 4 edges -> digit_valid[3]=0, bcd_out[15:12] stays 8, invalid_seen[3]=0.
- Reset asserted at edge 2 of a 4-edge run of digit 7 on slot 1 -> all outputs 0 immediately; after release, 4 more stable edges required before slot 1 = 7.
